// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: reads a byte-length message from word memory and streams
// 512-bit padded blocks one 32-bit word per handshake (data, 0x80 marker, zeros, bit length).
module sha256_msg_padder #(
  parameter int unsigned SIZE_W = 16,
  parameter int unsigned BLK_W  = 11,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [SIZE_W-1:0] msg_bytes,
  output logic              busy,
  output logic              done,
  output logic [BLK_W-1:0]  num_blocks,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [3:0]        out_word_idx,
  output logic [BLK_W-1:0]  out_block_idx,
  output logic              out_last
);

  localparam int unsigned WW = BLK_W + 4;   // global word index width
  localparam int unsigned BW = BLK_W + 6;   // global byte index width
  localparam int unsigned NW = SIZE_W + 1;  // block count at full precision

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_READ, S_WAIT, S_EMIT, S_DONE} state_t;

  state_t            state;
  logic [SIZE_W-1:0] len;
  logic [BLK_W-1:0]  blk_idx;
  logic [3:0]        word_idx;

  logic [NW-1:0]     nb_c;
  logic [BLK_W-1:0]  last_blk_c;
  logic              is_last_blk_c;
  logic [WW-1:0]     cur_w_c;
  logic [3:0]        nxt_word_c;
  logic [BLK_W-1:0]  nxt_blk_c;
  logic [WW-1:0]     nxt_w_c;
  logic              nxt_fin_c;
  logic              nxt_rd_c;

  // Builds one padded word: memory bytes below L, marker at L, zeros above; the
  // final block's last two words carry the 64-bit bit length instead.
  function automatic logic [31:0] pad_word(input logic [WW-1:0]     w,
                                           input logic [31:0]       data,
                                           input logic [SIZE_W-1:0] l,
                                           input logic              fin);
    logic [63:0]   len_bits;
    logic [BW-1:0] k;
    logic [31:0]   r;
    len_bits = 64'(l) << 3;
    r        = '0;
    if (fin && w[3:0] == 4'd14) begin
      r = len_bits[63:32];
    end else if (fin && w[3:0] == 4'd15) begin
      r = len_bits[31:0];
    end else begin
      for (int j = 0; j < 4; j++) begin
        k = {w, 2'b00} + BW'(j);
        if (k < BW'(l))       r[31-8*j -: 8] = data[31-8*j -: 8];
        else if (k == BW'(l)) r[31-8*j -: 8] = 8'h80;
      end
    end
    return r;
  endfunction

  assign nb_c          = ((NW'(len) + NW'(8)) >> 6) + NW'(1);
  assign last_blk_c    = BLK_W'(nb_c - NW'(1));
  assign is_last_blk_c = (blk_idx == last_blk_c);
  assign cur_w_c       = {blk_idx, word_idx};
  assign nxt_word_c    = word_idx + 4'd1;
  assign nxt_blk_c     = (word_idx == 4'hF) ? blk_idx + BLK_W'(1) : blk_idx;
  assign nxt_w_c       = {nxt_blk_c, nxt_word_c};
  assign nxt_fin_c     = (nxt_blk_c == last_blk_c);
  assign nxt_rd_c      = ({nxt_w_c, 2'b00} < BW'(len));

  assign out_word_idx  = word_idx;
  assign out_block_idx = blk_idx;

  // Control FSM with registered outputs; done and rd_req are single-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      len        <= '0;
      blk_idx    <= '0;
      word_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      num_blocks <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_last   <= 1'b0;
    end else begin
      done   <= 1'b0;
      rd_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len      <= msg_bytes;
            busy     <= 1'b1;
            blk_idx  <= '0;
            word_idx <= '0;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          num_blocks <= BLK_W'(nb_c);
          if (len != '0) begin
            rd_req  <= 1'b1;
            rd_addr <= ADDR_W'(cur_w_c);
            state   <= S_READ;
          end else begin
            out_word  <= pad_word(cur_w_c, 32'h0, len, is_last_blk_c);
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_EMIT;
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          out_word  <= pad_word(cur_w_c, rd_data, len, is_last_blk_c);
          out_last  <= is_last_blk_c && (word_idx == 4'hF);
          out_valid <= 1'b1;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              word_idx <= nxt_word_c;
              blk_idx  <= nxt_blk_c;
              if (nxt_rd_c) begin
                out_valid <= 1'b0;
                rd_req    <= 1'b1;
                rd_addr   <= ADDR_W'(nxt_w_c);
                state     <= S_READ;
              end else begin
                out_word <= pad_word(nxt_w_c, 32'h0, len, nxt_fin_c);
                out_last <= nxt_fin_c && (nxt_word_c == 4'hF);
              end
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
